// File: rtl/dense_pkg.sv
// Shared constants and state encoding for the dense layer controller.
// Also used by the dense datapath and its stream wrapper.
package dense_pkg;

    // Layer geometry and memory timing defaults shared across the layer
    localparam int IN_COUNT_DEF    = 1600;
    localparam int OUT_COUNT_DEF   = 10;
    localparam int MEM_LATENCY_DEF = 0;
    localparam int LAT_WIDTH_DEF   = 3;

    // Sequencer states, IDLE must stay at zero so reset decodes to all-quiet
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_MAC   = 3'd3,
        S_BIAS  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    // True when memory needs wait cycles after every address change
    function automatic logic lat_enabled(input int lat);
        return (lat > 0);
    endfunction

endpackage

// File: rtl/dense_latency_timer.sv
// Memory wait-cycle counter used by the FETCH state.
// Counts 0..MEM_LATENCY-1 and flags the last wait cycle.
module dense_latency_timer
    import dense_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int LAT_WIDTH   = LAT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    if (!lat_enabled(MEM_LATENCY)) begin : g_bypass
        // No wait cycles: terminal count is permanently reached
        logic unused_ok;
        assign unused_ok = ^{clk, rst, en_i, clr_i};
        assign tc_o = 1'b1;
    end else begin : g_count
        localparam logic [LAT_WIDTH-1:0] LAST = LAT_WIDTH'(MEM_LATENCY - 1);

        logic [LAT_WIDTH-1:0] cnt_q;
        logic [LAT_WIDTH-1:0] cnt_d;

        assign tc_o = (cnt_q == LAST);

        // Advance while enabled, wrap to zero after the last wait cycle
        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = tc_o ? '0 : cnt_q + 1'b1;
            end
        end

        // Counter register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/dense_controller.sv
// Sequencer for the fully-connected layer datapath.
// Walks inputs, adds bias, writes one result per neuron, then pulses done.
module dense_controller
    import dense_pkg::*;
#(
    parameter int IN_COUNT    = IN_COUNT_DEF,
    parameter int OUT_COUNT   = OUT_COUNT_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int LAT_WIDTH   = LAT_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    input  logic mulDone,
    input  logic calcDone,
    output logic clear,
    output logic clearReg,
    output logic inCntEn,
    output logic outCntEn,
    output logic load,
    output logic WorB,
    output logic out_we,
    output logic busy,
    output logic done
);

    localparam logic LAT_EN = lat_enabled(MEM_LATENCY);

    state_e state_q;
    state_e state_d;
    logic   lat_tc;
    logic   lat_en;
    logic   lat_clr;

    // Wait counter only runs in FETCH and is frozen by back-pressure
    assign lat_en  = (state_q == S_FETCH) && !hold;
    assign lat_clr = (state_q == S_IDLE);

    dense_latency_timer #(
        .MEM_LATENCY (MEM_LATENCY),
        .LAT_WIDTH   (LAT_WIDTH)
    ) u_lat (
        .clk   (clk),
        .rst   (rst),
        .en_i  (lat_en),
        .clr_i (lat_clr),
        .tc_o  (lat_tc)
    );

    // Next state and Moore strobe decode, with hold masking the strobes
    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        clearReg = 1'b0;
        inCntEn  = 1'b0;
        outCntEn = 1'b0;
        load     = 1'b0;
        WorB     = 1'b0;
        out_we   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                clear    = 1'b1;
                clearReg = 1'b1;
                state_d  = LAT_EN ? S_FETCH : S_MAC;
            end
            S_FETCH: begin
                if (lat_tc) begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                load    = 1'b1;
                inCntEn = 1'b1;
                if (mulDone) begin
                    state_d = S_BIAS;
                end else if (LAT_EN) begin
                    state_d = S_FETCH;
                end
            end
            S_BIAS: begin
                WorB    = 1'b1;
                out_we  = 1'b1;
                state_d = calcDone ? S_DONE : S_NEXT;
            end
            S_NEXT: begin
                outCntEn = 1'b1;
                clearReg = 1'b1;
                state_d  = LAT_EN ? S_FETCH : S_MAC;
            end
            S_DONE: begin
                done    = 1'b1;
                clear   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Back-pressure: freeze state, silence every datapath strobe
        if (hold) begin
            state_d  = state_q;
            clear    = 1'b0;
            clearReg = 1'b0;
            inCntEn  = 1'b0;
            outCntEn = 1'b0;
            load     = 1'b0;
            out_we   = 1'b0;
            done     = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe sanity checks for simulation
    always @(posedge clk) begin
        if (!rst) begin
            a_cfg: assert (IN_COUNT > 0 && OUT_COUNT > 0 &&
                           MEM_LATENCY >= 0 && MEM_LATENCY <= 7 &&
                           MEM_LATENCY < (1 << LAT_WIDTH))
                else $error("dense_controller: bad parameters");
            a_cnt: assert (!(inCntEn && outCntEn))
                else $error("dense_controller: both counters enabled");
            a_acc: assert (!(load && clearReg))
                else $error("dense_controller: load with clearReg");
            a_we: assert (!out_we || state_q == S_BIAS)
                else $error("dense_controller: out_we outside BIAS");
        end
    end

endmodule
